pov_column_sequencer: RTL and testbench

- Upstream feeder for the DotStar LED driver in the POV clock.
- Measures the rotation period from a hall-effect index sensor and divides each revolution into 2^COL_BITS equal angular columns.
- At each column boundary it fetches that column's pixel word from a synchronous frame memory, unpacks it into the per-LED R/G/B vectors and pulses write_data to start an LED update.

---
 rtl/pov_column_sequencer_if.sv | 25 ++
 rtl/pov_column_sequencer.sv | 128 ++++++++++++
 tb/tb_pov_column_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pov_column_sequencer_if.sv
// Column-sequencer bus: hall sensor input, frame-memory read port and LED-driver outputs.
// master = sequencer side, slave = memory/LED-driver/sensor side.
interface pov_column_sequencer_if #(
    parameter int NUM_LEDS = 8,
    parameter int COL_BITS = 6
);
    logic                     hall_in;
    logic [COL_BITS-1:0]      col_addr;
    logic [NUM_LEDS*24-1:0]   col_data;
    logic [NUM_LEDS*8-1:0]    led_r_vector;
    logic [NUM_LEDS*8-1:0]    led_g_vector;
    logic [NUM_LEDS*8-1:0]    led_b_vector;
    logic                     write_data;
    logic                     rev_valid;

    modport master (
        input  hall_in, col_data,
        output col_addr, led_r_vector, led_g_vector, led_b_vector, write_data, rev_valid
    );

    modport slave (
        output hall_in, col_data,
        input  col_addr, led_r_vector, led_g_vector, led_b_vector, write_data, rev_valid
    );
endinterface

// File: rtl/pov_column_sequencer.sv
// POV column sequencer: times each revolution from the hall index, splits it into
// 2^COL_BITS columns and feeds each column's pixels to the LED driver.
module pov_column_sequencer #(
    parameter int NUM_LEDS     = 8,
    parameter int COL_BITS     = 6,
    parameter int PERIOD_BITS  = 24,
    parameter int MIN_INTERVAL = 1200  // must be >= 4 so the column pipeline fits inside one interval
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    pov_column_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, MEASURE, FETCH, LATCH, STROBE, WAIT, BLANK} state_t;

    localparam logic [COL_BITS-1:0]    LAST_COL   = '1;
    localparam logic [PERIOD_BITS-1:0] PERIOD_MAX = '1;
    localparam logic [PERIOD_BITS-1:0] MIN_IVL    = PERIOD_BITS'(MIN_INTERVAL);
    localparam logic [PERIOD_BITS-1:0] PIPE_ADJ   = PERIOD_BITS'(4);

    state_t                  state, state_next;
    logic                    hall_meta, hall_sync, hall_prev, hall_rise;
    logic [PERIOD_BITS-1:0]  period_cnt, last_period, interval, timer;
    logic [COL_BITS-1:0]     column;
    logic [NUM_LEDS*8-1:0]   r_vec, g_vec, b_vec;
    logic                    stall;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            hall_meta <= 1'b0;
            hall_sync <= 1'b0;
            hall_prev <= 1'b0;
            hall_rise <= 1'b0;
        end else begin
            hall_meta <= bus.hall_in;
            hall_sync <= hall_meta;
            hall_prev <= hall_sync;
            hall_rise <= hall_sync & ~hall_prev;
        end
    end

    // The captured count includes the index cycle, so it equals the edge-to-edge distance.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            period_cnt  <= '0;
            last_period <= '0;
        end else if (hall_rise) begin
            last_period <= (period_cnt == PERIOD_MAX) ? PERIOD_MAX : period_cnt + 1'b1;
            period_cnt  <= '0;
        end else if (period_cnt != PERIOD_MAX) begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    assign interval = ((last_period >> COL_BITS) > MIN_IVL) ? (last_period >> COL_BITS) : MIN_IVL;
    assign stall    = (period_cnt == PERIOD_MAX) && !hall_rise;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (hall_rise) state_next = MEASURE;
            MEASURE: if (hall_rise) state_next = FETCH;
                     else if (stall) state_next = IDLE;
            FETCH:   state_next = LATCH;
            LATCH:   state_next = STROBE;
            STROBE:  state_next = WAIT;
            WAIT:    if (timer == '0 && column != LAST_COL) state_next = FETCH;
            BLANK:   state_next = hall_rise ? MEASURE : IDLE;
            default: state_next = IDLE;
        endcase
        if (state inside {FETCH, LATCH, STROBE, WAIT}) begin
            if (hall_rise)  state_next = FETCH;
            else if (stall) state_next = BLANK;
        end
    end

    always_comb begin
        bus.write_data = (state == STROBE) || (state == BLANK);
        bus.rev_valid  = state inside {FETCH, LATCH, STROBE, WAIT};
    end

    // Reload leaves room for FETCH/LATCH/STROBE so strobes land exactly one interval apart.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            column <= '0;
            timer  <= '0;
        end else begin
            if (hall_rise)
                column <= '0;
            else if (state == WAIT && state_next == FETCH)
                column <= column + 1'b1;
            if (state == STROBE)
                timer <= interval - PIPE_ADJ;
            else if (state == WAIT && timer != '0)
                timer <= timer - 1'b1;
        end
    end

    // Vectors only move on a committed LATCH or when blanking, so they hold between pulses.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_vec <= '0;
            g_vec <= '0;
            b_vec <= '0;
        end else if (state_next == BLANK) begin
            r_vec <= '0;
            g_vec <= '0;
            b_vec <= '0;
        end else if (state == LATCH && state_next == STROBE) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_vec[i*8 +: 8] <= bus.col_data[i*24      +: 8];
                g_vec[i*8 +: 8] <= bus.col_data[i*24 + 8  +: 8];
                b_vec[i*8 +: 8] <= bus.col_data[i*24 + 16 +: 8];
            end
        end
    end

    assign bus.col_addr     = column;
    assign bus.led_r_vector = r_vec;
    assign bus.led_g_vector = g_vec;
    assign bus.led_b_vector = b_vec;
endmodule

// File: tb/tb_pov_column_sequencer.sv
// Bench for pov_column_sequencer: directed hall timing, expected strobes queued per edge,
// a negedge monitor pops and compares each write_data pulse.
module tb_pov_column_sequencer;
    localparam int NUM_LEDS     = 4;
    localparam int COL_BITS     = 3;
    localparam int PERIOD_BITS  = 10;
    localparam int MIN_INTERVAL = 10;
    localparam int VW           = NUM_LEDS * 8;

    typedef struct {
        int            cyc;
        int            col;
        logic [VW-1:0] r, g, b;
        logic          active;
    } pulse_t;

    logic   sys_clk = 1'b0;
    logic   rst     = 1'b0;
    int     cyc     = 0;
    int     n_checks = 0;
    int     n_pass   = 0;
    pulse_t exp_q[$];

    pov_column_sequencer_if #(.NUM_LEDS(NUM_LEDS), .COL_BITS(COL_BITS)) bus();

    pov_column_sequencer #(
        .NUM_LEDS(NUM_LEDS), .COL_BITS(COL_BITS),
        .PERIOD_BITS(PERIOD_BITS), .MIN_INTERVAL(MIN_INTERVAL)
    ) dut (
        .sys_clk(sys_clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic [NUM_LEDS*24-1:0] mem_row(input logic [COL_BITS-1:0] c);
        logic [NUM_LEDS*24-1:0] row;
        logic [7:0] cb, rr, gg, bb;
        cb = 8'(c);
        rr = 8'h10 + cb;
        gg = 8'h50 + cb;
        bb = 8'hA0 + cb;
        for (int i = 0; i < NUM_LEDS; i++) row[i*24 +: 24] = {bb, gg, rr};
        return row;
    endfunction

    initial bus.col_data = '0;
    always @(posedge sys_clk) bus.col_data <= mem_row(bus.col_addr);

    function automatic logic [VW-1:0] rep(input logic [7:0] v);
        logic [VW-1:0] x;
        for (int i = 0; i < NUM_LEDS; i++) x[i*8 +: 8] = v;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic expect_cols(input int start, input int ivl, input int n);
        for (int k = 0; k < n; k++)
            exp_q.push_back('{start + k*ivl, k, rep(8'(8'h10 + k)), rep(8'(8'h50 + k)),
                              rep(8'(8'hA0 + k)), 1'b1});
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Raises hall_in 3 time units after the edge that starts cycle 'at', for 'width' cycles.
    task automatic hall_pulse(input int at, input int width);
        wait_until(at);
        #2;
        bus.hall_in = 1'b1;
        #(10 * width);
        bus.hall_in = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_write_data"}, bus.write_data, 0);
        check({tag, "_rev_valid"}, bus.rev_valid, 0);
        check({tag, "_col_addr"}, bus.col_addr, 0);
        check({tag, "_led_r"}, bus.led_r_vector, 0);
        check({tag, "_led_g"}, bus.led_g_vector, 0);
        check({tag, "_led_b"}, bus.led_b_vector, 0);
    endtask

    always @(negedge sys_clk) begin
        pulse_t e;
        if (bus.write_data === 1'b1) begin
            check("pulse_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                if (e.active) check("pulse_col_addr", bus.col_addr, e.col);
                check("pulse_rev_valid", bus.rev_valid, e.active);
                check("pulse_led_r", bus.led_r_vector, e.r);
                check("pulse_led_g", bus.led_g_vector, e.g);
                check("pulse_led_b", bus.led_b_vector, e.b);
            end
        end
    end

    initial begin
        int h0, h1, h2, h3, h4, h5, h6, h7, h8, h9, h10;
        bus.hall_in = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Steady rotation: 800-cycle revolutions -> 100-cycle columns.
        h0 = 20;       hall_pulse(h0, 3);
        wait_until(h0 + 10);
        check("measure_rev_valid", bus.rev_valid, 0);
        h1 = h0 + 800; hall_pulse(h1, 2);
        expect_cols(h1 + 6, 100, 8);
        wait_until(h1 + 50);
        check("steady_rev_valid", bus.rev_valid, 1);

        // Clamp: 40-cycle revolutions -> interval 10, columns 0..3 then abort.
        h2 = h1 + 800; hall_pulse(h2, 2);
        expect_cols(h2 + 6, 100, 1);
        h3 = h2 + 40;  hall_pulse(h3, 2);
        expect_cols(h3 + 6, 10, 4);
        h4 = h3 + 40;  hall_pulse(h4, 2);
        expect_cols(h4 + 6, 10, 8);

        // Early index landing in LATCH of column 5; one-cycle glitchy hall pulse.
        h5 = h4 + 800; hall_pulse(h5, 3);
        expect_cols(h5 + 6, 100, 5);
        h6 = h5 + 502; hall_pulse(h6, 1);
        expect_cols(h6 + 6, 62, 8);

        // Stall: counter saturates at 1023 -> one blanking pulse.
        exp_q.push_back('{h6 + 1028, 0, '0, '0, '0, 1'b0});
        wait_until(h6 + 1035);
        check("stall_rev_valid", bus.rev_valid, 0);
        check("stall_led_r", bus.led_r_vector, 0);

        // Reset mid-WAIT, then a single edge must not produce any pulse.
        h7 = h6 + 1100; hall_pulse(h7, 2);
        h8 = h7 + 40;   hall_pulse(h8, 2);
        expect_cols(h8 + 6, 10, 2);
        wait_until(h8 + 20);
        rst = 1'b1;
        #1;
        check_outputs_zero("midwait_reset");
        repeat (5) @(posedge sys_clk);
        #1;
        check("reset_held_write_data", bus.write_data, 0);
        rst = 1'b0;
        h9 = h8 + 40;   hall_pulse(h9, 2);
        wait_until(h9 + 20);
        check("post_reset_rev_valid", bus.rev_valid, 0);
        h10 = h9 + 80;  hall_pulse(h10, 2);
        expect_cols(h10 + 6, 10, 8);

        wait_until(h10 + 120);
        check("final_hold_rev_valid", bus.rev_valid, 1);
        check("all_pulses_seen", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
